// File: rtl/vec_operand_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vec_operand_fetch : walks two VRF read ports and streams paired beats out  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module vec_operand_fetch #(
  parameter int VLEN       = 16384,
  parameter int DATA_WIDTH = 64,
  parameter int DW_B       = DATA_WIDTH >> 3,
  parameter int ADDR_WIDTH = 5,
  parameter int OFF_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_vs1,
  input  logic [ADDR_WIDTH-1:0] req_vs2,
  input  logic                  req_use_vs2,
  input  logic [OFF_BITS:0]     req_beats,
  input  logic [DW_B-1:0]       req_last_mask,
  output logic [DW_B-1:0]       rd_en_1,
  output logic [DW_B-1:0]       rd_en_2,
  output logic [ADDR_WIDTH-1:0] rd_addr_1,
  output logic [ADDR_WIDTH-1:0] rd_addr_2,
  output logic [OFF_BITS-1:0]   rd_off_1,
  output logic [OFF_BITS-1:0]   rd_off_2,
  input  logic [DATA_WIDTH-1:0] rd_data_1,
  input  logic [DATA_WIDTH-1:0] rd_data_2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data_1,
  output logic [DATA_WIDTH-1:0] out_data_2,
  output logic [DW_B-1:0]       out_mask,
  output logic                  out_last,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int              MAX_BEATS_I = VLEN / DATA_WIDTH;
  localparam logic [OFF_BITS:0] MAX_BEATS = MAX_BEATS_I[OFF_BITS:0];
  localparam logic [OFF_BITS:0] ONE_BEAT  = {{OFF_BITS{1'b0}}, 1'b1};

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] vs1_q, vs2_q;
  logic                  use_vs2_q;
  logic [DW_B-1:0]       last_mask_q;
  logic [OFF_BITS:0]     remaining_q;
  logic [OFF_BITS-1:0]   off_q, off_hold_q;
  logic                  inflight_q, infl_last_q;
  logic [DW_B-1:0]       infl_mask_q;

  logic [DATA_WIDTH-1:0] fifo_d1_q [2];
  logic [DATA_WIDTH-1:0] fifo_d2_q [2];
  logic [DW_B-1:0]       fifo_mask_q [2];
  logic [1:0]            fifo_last_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;

  logic                  accept, issue, push, pop, last_issue;
  logic [2:0]            credit;
  logic [DW_B-1:0]       cur_mask;
  logic [OFF_BITS:0]     beats_clamped;

  assign req_ready = (state_q == S_IDLE);
  assign busy      = ~req_ready;
  assign accept    = req_valid & req_ready & (req_beats != '0);

  // Out-of-range beat counts are clamped so the offset can never wrap.
  assign beats_clamped = (req_beats > MAX_BEATS) ? MAX_BEATS : req_beats;

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = inflight_q;

  // Entries already owed to the FIFO (stored + in flight) minus this cycle's pop.
  assign credit     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue      = (state_q == S_ISSUE) && (credit < 3'd2);
  assign last_issue = (remaining_q == ONE_BEAT);
  assign cur_mask   = last_issue ? last_mask_q : {DW_B{1'b1}};

  assign rd_en_1   = issue ? cur_mask : '0;
  assign rd_en_2   = (issue && use_vs2_q) ? cur_mask : '0;
  assign rd_addr_1 = vs1_q;
  assign rd_addr_2 = vs2_q;
  assign rd_off_1  = issue ? off_q : off_hold_q;
  assign rd_off_2  = issue ? off_q : off_hold_q;

  assign out_data_1 = out_valid ? fifo_d1_q[rd_ptr_q]   : '0;
  assign out_data_2 = out_valid ? fifo_d2_q[rd_ptr_q]   : '0;
  assign out_mask   = out_valid ? fifo_mask_q[rd_ptr_q] : '0;
  assign out_last   = out_valid & fifo_last_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: if (issue && last_issue) state_d = S_DRAIN;
      S_DRAIN: if (pop && out_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      vs1_q       <= '0;
      vs2_q       <= '0;
      use_vs2_q   <= 1'b0;
      last_mask_q <= '0;
      remaining_q <= '0;
      off_q       <= '0;
      off_hold_q  <= '0;
      inflight_q  <= 1'b0;
      infl_mask_q <= '0;
      infl_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (accept) begin
        vs1_q       <= req_vs1;
        vs2_q       <= req_vs2;
        use_vs2_q   <= req_use_vs2;
        last_mask_q <= req_last_mask;
        remaining_q <= beats_clamped;
        off_q       <= '0;
      end else if (issue) begin
        off_hold_q  <= off_q;
        off_q       <= off_q + 1'b1;
        remaining_q <= remaining_q - ONE_BEAT;
        infl_mask_q <= cur_mask;
        infl_last_q <= last_issue;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_d1_q[i]   <= '0;
        fifo_d2_q[i]   <= '0;
        fifo_mask_q[i] <= '0;
      end
      fifo_last_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_d1_q[wr_ptr_q]   <= rd_data_1;
        fifo_d2_q[wr_ptr_q]   <= rd_data_2;
        fifo_mask_q[wr_ptr_q] <= infl_mask_q;
        fifo_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vec_operand_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vec_operand_fetch : randomized bench with a beat-queue reference model  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_vec_operand_fetch;

  localparam int DW  = 64;
  localparam int DWB = 8;
  localparam int AW  = 5;
  localparam int OB  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_vs1 = '0;
  logic [AW-1:0] req_vs2 = '0;
  logic          req_use_vs2 = 1'b0;
  logic [OB:0]   req_beats = '0;
  logic [DWB-1:0] req_last_mask = '0;
  logic [DWB-1:0] rd_en_1, rd_en_2;
  logic [AW-1:0] rd_addr_1, rd_addr_2;
  logic [OB-1:0] rd_off_1, rd_off_2;
  logic [DW-1:0] rd_data_1 = '0;
  logic [DW-1:0] rd_data_2 = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data_1, out_data_2;
  logic [DWB-1:0] out_mask;
  logic          out_last;
  logic          busy;

  vec_operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vs1(req_vs1), .req_vs2(req_vs2), .req_use_vs2(req_use_vs2),
    .req_beats(req_beats), .req_last_mask(req_last_mask),
    .rd_en_1(rd_en_1), .rd_en_2(rd_en_2),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_off_1(rd_off_1), .rd_off_2(rd_off_2),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data_1(out_data_1), .out_data_2(out_data_2),
    .out_mask(out_mask), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0]  d1;
    logic [DW-1:0]  d2;
    logic [DWB-1:0] m;
    logic           l;
  } beat_t;

  logic [DW-1:0] rf [32][256];
  int n_total = 0;
  int n_pass  = 0;

  // Reference model state, advanced once per cycle by the compare process.
  beat_t         exp_q [$];
  bit            mbusy = 1'b0;
  bit            muse = 1'b0;
  logic [AW-1:0] mvs1 = '0, mvs2 = '0;
  logic [DWB-1:0] mlm = '0;
  int            mn = 0, m_issued = 0, m_popped = 0, mmax_off = 0;
  bit            prev_stall = 1'b0;
  bit            rand_ready = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
  endtask

  // Register file: read data appears one cycle after the address/offset.
  initial begin
    logic [AW-1:0] a1, a2;
    logic [OB-1:0] o1, o2;
    forever begin
      @(negedge clk);
      a1 = rd_addr_1; a2 = rd_addr_2; o1 = rd_off_1; o2 = rd_off_2;
      @(posedge clk);
      #1;
      rd_data_1 = rf[a1][o1];
      rd_data_2 = rf[a2][o2];
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? ($urandom_range(0, 99) < 55) : 1'b1;
    end
  end

  always @(negedge clk) begin
    beat_t          h;
    bit             pop;
    logic [DWB-1:0] exp_mask;
    if (!rst_n) begin
      exp_q.delete();
      mbusy = 1'b0;
      prev_stall = 1'b0;
    end else begin
      pop = out_valid && out_ready;
      chk("req_ready", {63'b0, req_ready}, {63'b0, !mbusy});
      chk("busy", {63'b0, busy}, {63'b0, mbusy});
      if (!mbusy) begin
        chk("idle_rd_en_1", {56'b0, rd_en_1}, 64'h0);
        chk("idle_rd_en_2", {56'b0, rd_en_2}, 64'h0);
      end else if (!muse) begin
        chk("rd_en_2_unused", {56'b0, rd_en_2}, 64'h0);
      end
      if (rd_en_1 != '0 || rd_en_2 != '0) begin
        exp_mask = (m_issued == mn - 1) ? mlm : 8'hFF;
        chk("rd_en_1", {56'b0, rd_en_1}, {56'b0, exp_mask});
        chk("rd_en_2", {56'b0, rd_en_2}, {56'b0, (muse ? exp_mask : 8'h00)});
        chk("rd_addr_1", {59'b0, rd_addr_1}, {59'b0, mvs1});
        chk("rd_addr_2", {59'b0, rd_addr_2}, {59'b0, mvs2});
        chk("rd_off_1", {56'b0, rd_off_1}, 64'(m_issued));
        chk("rd_off_2", {56'b0, rd_off_2}, 64'(m_issued));
        chk("credit", {63'b0, ((m_issued - m_popped - int'(pop)) < 2)}, 64'h1);
        if (int'(rd_off_1) > mmax_off) mmax_off = int'(rd_off_1);
        m_issued++;
      end
      if (prev_stall) chk("stall_hold_valid", {63'b0, out_valid}, 64'h1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected", {63'b0, out_valid}, 64'h0);
        end else begin
          h = exp_q[0];
          chk("out_data_1", out_data_1, h.d1);
          if (muse) chk("out_data_2", out_data_2, h.d2);
          chk("out_mask", {56'b0, out_mask}, {56'b0, h.m});
          chk("out_last", {63'b0, out_last}, {63'b0, h.l});
          if (pop) begin
            void'(exp_q.pop_front());
            m_popped++;
            if (h.l) mbusy = 1'b0;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      if (req_valid && req_ready && req_beats != '0) begin
        mn = int'(req_beats);
        mvs1 = req_vs1; mvs2 = req_vs2; muse = req_use_vs2; mlm = req_last_mask;
        m_issued = 0; m_popped = 0; mmax_off = 0;
        for (int i = 0; i < mn; i++) begin
          h.d1 = rf[req_vs1][i];
          h.d2 = rf[req_vs2][i];
          h.l  = (i == mn - 1);
          h.m  = h.l ? req_last_mask : 8'hFF;
          exp_q.push_back(h);
        end
        mbusy = 1'b1;
      end
    end
  end

  task automatic send(input int vs1, input int vs2, input bit use2, input int beats, input logic [7:0] lm);
    @(posedge clk);
    #1;
    req_vs1 = AW'(vs1); req_vs2 = AW'(vs2); req_use_vs2 = use2;
    req_beats = (OB+1)'(beats); req_last_mask = lm; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while ((mbusy || !req_ready) && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(nm, {63'b0, (t < 5000)}, 64'h1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready", {63'b0, req_ready}, 64'h1);
    chk("rst_busy", {63'b0, busy}, 64'h0);
    chk("rst_out_valid", {63'b0, out_valid}, 64'h0);
    chk("rst_out_last", {63'b0, out_last}, 64'h0);
    chk("rst_out_mask", {56'b0, out_mask}, 64'h0);
    chk("rst_out_data_1", out_data_1, 64'h0);
    chk("rst_out_data_2", out_data_2, 64'h0);
    chk("rst_rd_en_1", {56'b0, rd_en_1}, 64'h0);
    chk("rst_rd_en_2", {56'b0, rd_en_2}, 64'h0);
    chk("rst_rd_addr_1", {59'b0, rd_addr_1}, 64'h0);
    chk("rst_rd_addr_2", {59'b0, rd_addr_2}, 64'h0);
    chk("rst_rd_off_1", {56'b0, rd_off_1}, 64'h0);
    chk("rst_rd_off_2", {56'b0, rd_off_2}, 64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_en, first_v, ready_back, cnt, t;
    for (int a = 0; a < 32; a++)
      for (int o = 0; o < 256; o++)
        rf[a][o] = {$urandom, $urandom};
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    rst_n = 1'b1;

    // Four-beat request, no backpressure: latency and offset sequence pinned by hand.
    send(3, 7, 1'b1, 4, 8'hFF);
    first_en = -1; first_v = -1; ready_back = -1;
    for (int k = 1; k <= 10; k++) begin
      if (first_en < 0 && rd_en_1 != '0) first_en = k;
      if (first_v < 0 && out_valid) first_v = k;
      if (ready_back < 0 && req_ready) ready_back = k;
      if (k <= 4) chk("t1_rd_off", {56'b0, rd_off_1}, 64'(k - 1));
      if (k == 3) chk("t1_beat0_d2", out_data_2, rf[7][0]);
      if (k == 5) chk("t1_not_last", {63'b0, out_last}, 64'h0);
      if (k == 6) chk("t1_last", {63'b0, out_last & out_valid}, 64'h1);
      @(posedge clk);
      #1;
    end
    chk("t1_first_rd_en_cycle", 64'(first_en), 64'd1);
    chk("t1_first_valid_cycle", 64'(first_v), 64'd3);
    chk("t1_ready_return_cycle", 64'(ready_back), 64'd7);

    // Single beat with a partial mask.
    send(1, 2, 1'b1, 1, 8'h0F);
    cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      if (rd_en_1 == 8'h0F) begin
        cnt++;
        chk("t2_rd_en_2", {56'b0, rd_en_2}, 64'h0F);
      end
      @(posedge clk);
      #1;
    end
    chk("t2_issue_count", 64'(cnt), 64'd1);
    wait_idle("t2_timeout");
    chk("t2_beats", 64'(m_popped), 64'd1);

    // Port 2 disabled.
    send(5, 9, 1'b0, 3, 8'hFF);
    wait_idle("t3_timeout");
    chk("t3_beats", 64'(m_popped), 64'd3);

    // Zero beats: nothing happens.
    send(4, 4, 1'b1, 0, 8'hFF);
    for (int k = 0; k < 6; k++) begin
      chk("t0_req_ready", {63'b0, req_ready}, 64'h1);
      chk("t0_rd_en", {56'b0, rd_en_1}, 64'h0);
      chk("t0_out_valid", {63'b0, out_valid}, 64'h0);
      @(posedge clk);
      #1;
    end

    // All-zero final mask still yields a beat.
    send(6, 8, 1'b1, 2, 8'h00);
    wait_idle("tz_timeout");
    chk("tz_beats", 64'(m_popped), 64'd2);

    // Random requests under random backpressure.
    rand_ready = 1'b1;
    for (int r = 0; r < 12; r++) begin
      send($urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom_range(0, 1)),
           $urandom_range(1, 40), 8'($urandom_range(1, 255)));
      wait_idle("rand_timeout");
    end

    // Full-length register.
    send($urandom_range(0, 31), $urandom_range(0, 31), 1'b1, 256, 8'($urandom_range(1, 255)));
    wait_idle("t256_timeout");
    chk("t256_beats", 64'(m_popped), 64'd256);
    chk("t256_max_off", 64'(mmax_off), 64'd255);

    // Asynchronous reset in the middle of a request.
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(10, 11, 1'b1, 20, 8'hFF);
    t = 0;
    while (m_popped < 5 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("trst_reach5_timeout", {63'b0, (t < 200)}, 64'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    send(12, 13, 1'b1, 2, 8'h3C);
    wait_idle("trst_new_timeout");
    chk("trst_new_beats", 64'(m_popped), 64'd2);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
